// File: rtl/rega_pkg.sv
// Shared types and state codes for the irrigation master controller.
package rega_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENCHE,
      REGA,
      LIMPA,
      FALHA
   } estado_t;

   localparam logic [1:0] MEF_IDLE  = 2'b00;
   localparam logic [1:0] MEF_ENCHE = 2'b01;
   localparam logic [1:0] MEF_LIMPA = 2'b10;
   localparam logic [1:0] MEF_REGA  = 2'b11;

   // FALHA reports as idle on mef1; the fault itself is visible on alarme.
   function automatic logic [1:0] mef_code(input estado_t st);
      case (st)
         ENCHE:   mef_code = MEF_ENCHE;
         REGA:    mef_code = MEF_REGA;
         LIMPA:   mef_code = MEF_LIMPA;
         default: mef_code = MEF_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/temporizador_mef.sv
// Loadable down counter with a zero flag; shared duration timer of the irrigation FSM.
module temporizador_mef #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturates at zero: the owning state leaves on the edge that sees zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/controle_rega.sv
// Irrigation master FSM: tank fill, timed irrigation, timed line cleaning, latched fault.
module controle_rega
   import rega_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int T_REGA_ASP  = 8,
   parameter int T_REGA_GOT  = 16,
   parameter int T_LIMPEZA   = 4,
   parameter int T_ENCHE_MAX = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       umidade_baixa,
   input  logic       nivel_baixo,
   input  logic       nivel_alto,
   input  logic       modo,
   input  logic       erro_in,
   input  logic       reconhece,
   output logic [1:0] mef1,
   output logic       asp,
   output logic       got,
   output logic       VE,
   output logic       limpeza,
   output logic       alarme
);

   // A load of D-1 gives exactly D cycles in the loaded state.
   localparam logic [CNT_W-1:0] LD_ENCHE = CNT_W'(T_ENCHE_MAX - 1);
   localparam logic [CNT_W-1:0] LD_ASP   = CNT_W'(T_REGA_ASP - 1);
   localparam logic [CNT_W-1:0] LD_GOT   = CNT_W'(T_REGA_GOT - 1);
   localparam logic [CNT_W-1:0] LD_LIMPA = CNT_W'(T_LIMPEZA - 1);

   estado_t          state_q, state_d;
   logic             modo_q, modo_d;
   logic             cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;

   temporizador_mef #(.CNT_W(CNT_W)) u_temporizador (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         modo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         modo_q  <= modo_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      modo_d       = modo_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_en       = 1'b0;
      if ((state_q != FALHA) && erro_in) begin
         state_d = FALHA;
      end else if (nivel_baixo && nivel_alto) begin
         state_d = FALHA;
      end else begin
         case (state_q)
            IDLE: begin
               if (nivel_baixo) begin
                  state_d      = ENCHE;
                  cnt_load     = 1'b1;
                  cnt_load_val = LD_ENCHE;
               end else if (umidade_baixa) begin
                  state_d      = REGA;
                  modo_d       = modo;
                  cnt_load     = 1'b1;
                  cnt_load_val = modo ? LD_ASP : LD_GOT;
               end
            end
            ENCHE: begin
               if (nivel_alto) begin
                  state_d = IDLE;
               end else if (cnt_zero) begin
                  state_d = FALHA;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            REGA: begin
               if (cnt_zero || !umidade_baixa || nivel_baixo) begin
                  state_d      = LIMPA;
                  cnt_load     = 1'b1;
                  cnt_load_val = LD_LIMPA;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            LIMPA: begin
               if (cnt_zero) begin
                  state_d = IDLE;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            FALHA: begin
               if (reconhece && !erro_in) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      mef1    = mef_code(state_q);
      asp     = (state_q == REGA) &&  modo_q;
      got     = (state_q == REGA) && !modo_q;
      VE      = (state_q == ENCHE);
      limpeza = (state_q == LIMPA);
      alarme  = (state_q == FALHA);
   end

endmodule

// File: tb/tb_controle_rega.sv
// Bench for controle_rega: directed scenarios plus random traffic against a cycle-level model.
module tb_controle_rega;

   logic       clk;
   logic       reset;
   logic       umidade_baixa, nivel_baixo, nivel_alto, modo, erro_in, reconhece;
   logic [1:0] mef1;
   logic       asp, got, VE, limpeza, alarme;

   int checks = 0;
   int fails  = 0;
   bit mon_en = 1'b0;

   // Reference model: a phase name plus the number of cycles still to spend in it.
   string m_phase = "IDLE";
   int    m_left  = 0;
   bit    m_modo  = 1'b0;

   controle_rega dut (
      .clk           (clk),
      .reset         (reset),
      .umidade_baixa (umidade_baixa),
      .nivel_baixo   (nivel_baixo),
      .nivel_alto    (nivel_alto),
      .modo          (modo),
      .erro_in       (erro_in),
      .reconhece     (reconhece),
      .mef1          (mef1),
      .asp           (asp),
      .got           (got),
      .VE            (VE),
      .limpeza       (limpeza),
      .alarme        (alarme)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ((asp & got) !== 1'b0) begin
            fails++;
            $display("FAIL inv_asp_got t=%0t asp=%b got=%b required asp&got=0", $time, asp, got);
         end
         checks++;
         if ((VE & (asp | got)) !== 1'b0) begin
            fails++;
            $display("FAIL inv_ve_excl t=%0t VE=%b asp=%b got=%b required VE&(asp|got)=0",
                     $time, VE, asp, got);
         end
      end
   end

   function automatic void model_edge();
      if (reset) begin
         m_phase = "IDLE"; m_left = 0; m_modo = 1'b0;
      end else if (m_phase != "FALHA" && erro_in) begin
         m_phase = "FALHA";
      end else if (nivel_baixo && nivel_alto) begin
         m_phase = "FALHA";
      end else if (m_phase == "IDLE") begin
         if (nivel_baixo) begin
            m_phase = "ENCHE"; m_left = 32;
         end else if (umidade_baixa) begin
            m_phase = "REGA"; m_modo = modo; m_left = modo ? 8 : 16;
         end
      end else if (m_phase == "ENCHE") begin
         if (nivel_alto) m_phase = "IDLE";
         else if (m_left == 1) m_phase = "FALHA";
         else m_left--;
      end else if (m_phase == "REGA") begin
         if (m_left == 1 || !umidade_baixa || nivel_baixo) begin
            m_phase = "LIMPA"; m_left = 4;
         end else m_left--;
      end else if (m_phase == "LIMPA") begin
         if (m_left == 1) m_phase = "IDLE";
         else m_left--;
      end else if (m_phase == "FALHA") begin
         if (reconhece && !erro_in) m_phase = "IDLE";
      end
   endfunction

   // Packed as {mef1, asp, got, VE, limpeza, alarme}.
   function automatic logic [6:0] exp_vec();
      case (m_phase)
         "ENCHE": exp_vec = 7'b01_0_0_1_0_0;
         "REGA":  exp_vec = {2'b11, m_modo, ~m_modo, 3'b000};
         "LIMPA": exp_vec = 7'b10_0_0_0_1_0;
         "FALHA": exp_vec = 7'b00_0_0_0_0_1;
         default: exp_vec = 7'b00_0_0_0_0_0;
      endcase
   endfunction

   function automatic logic [6:0] dut_vec();
      dut_vec = {mef1, asp, got, VE, limpeza, alarme};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      umidade_baixa = 0; nivel_baixo = 0; nivel_alto = 0;
      modo = 0; erro_in = 0; reconhece = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) begin
         tick();
         checks++;
         if (dut_vec() !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs got=%b required=%b", dut_vec(), 7'b0);
         end
      end
      reset = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_asp_cycle();
      int asp_n = 0, lim_n = 0;
      umidade_baixa = 1; modo = 1;
      for (int i = 0; i < 13; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL asp_cycle_vec cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
         if (asp === 1'b1 && mef1 === 2'b11) asp_n++;
         if (limpeza === 1'b1 && mef1 === 2'b10) begin
            lim_n++;
            umidade_baixa = 0;
         end
      end
      checks++;
      if (asp_n != 8) begin
         fails++; $display("FAIL asp_duration got=%0d required=8", asp_n);
      end
      checks++;
      if (lim_n != 4) begin
         fails++; $display("FAIL asp_clean_duration got=%0d required=4", lim_n);
      end
      checks++;
      if (mef1 !== 2'b00) begin
         fails++; $display("FAIL asp_back_idle got=%b required=00", mef1);
      end
      idle_inputs();
   endtask

   task automatic test_fill_then_drip();
      int got_n = 0;
      nivel_baixo = 1; umidade_baixa = 1; modo = 0;
      tick();
      checks++;
      if (mef1 !== 2'b01 || VE !== 1'b1) begin
         fails++; $display("FAIL fill_first mef1=%b VE=%b required mef1=01 VE=1", mef1, VE);
      end
      repeat (4) tick();
      nivel_baixo = 0; nivel_alto = 1;
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || mef1 !== 2'b00) begin
         fails++; $display("FAIL fill_done got=%b required=%b", dut_vec(), exp_vec());
      end
      for (int i = 0; i < 22; i++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL drip_vec cyc=%0d got=%b required=%b", i, dut_vec(), exp_vec());
         end
         if (got === 1'b1) got_n++;
         if (limpeza === 1'b1) umidade_baixa = 0;
      end
      checks++;
      if (got_n != 16) begin
         fails++; $display("FAIL drip_duration got=%0d required=16", got_n);
      end
      idle_inputs();
   endtask

   task automatic test_fill_timeout();
      int ve_n = 0;
      nivel_baixo = 1;
      for (int i = 0; i < 36; i++) begin
         tick();
         if (VE === 1'b1) ve_n++;
      end
      checks++;
      if (ve_n != 32) begin
         fails++; $display("FAIL fill_timeout_len got=%0d required=32", ve_n);
      end
      checks++;
      if (alarme !== 1'b1 || mef1 !== 2'b00 || dut_vec() !== exp_vec()) begin
         fails++; $display("FAIL fill_timeout_alarm got=%b required=%b", dut_vec(), exp_vec());
      end
      nivel_baixo = 0; reconhece = 1;
      tick();
      checks++;
      if (dut_vec() !== 7'b0) begin
         fails++; $display("FAIL timeout_ack got=%b required=%b", dut_vec(), 7'b0);
      end
      idle_inputs();
   endtask

   task automatic test_validator_fault();
      umidade_baixa = 1; modo = 1;
      repeat (3) tick();
      erro_in = 1;
      tick();
      checks++;
      if (dut_vec() !== 7'b00_0_0_0_0_1) begin
         fails++; $display("FAIL erro_to_fault got=%b required=%b", dut_vec(), 7'b0000001);
      end
      reconhece = 1;
      tick();
      checks++;
      if (alarme !== 1'b1) begin
         fails++; $display("FAIL ack_blocked_by_erro alarme=%b required=1", alarme);
      end
      erro_in = 0; umidade_baixa = 0;
      tick();
      checks++;
      if (dut_vec() !== 7'b0 || dut_vec() !== exp_vec()) begin
         fail_print_ack: begin
            fails++; $display("FAIL fault_ack got=%b required=%b", dut_vec(), 7'b0);
         end
      end
      idle_inputs();
   endtask

   task automatic test_early_stop_reset();
      int lim_n = 0;
      umidade_baixa = 1; modo = 0;
      repeat (2) tick();
      umidade_baixa = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (limpeza === 1'b1) lim_n++;
      end
      checks++;
      if (lim_n != 4 || mef1 !== 2'b00) begin
         fails++; $display("FAIL early_stop lim_cycles=%0d mef1=%b required 4 and 00", lim_n, mef1);
      end
      umidade_baixa = 1;
      repeat (2) tick();
      umidade_baixa = 0;
      repeat (2) tick();
      checks++;
      if (limpeza !== 1'b1) begin
         fails++; $display("FAIL in_limpa limpeza=%b required=1", limpeza);
      end
      reset = 1;
      tick();
      checks++;
      if (dut_vec() !== 7'b0) begin
         fails++; $display("FAIL reset_mid_limpa got=%b required=%b", dut_vec(), 7'b0);
      end
      reset = 0;
      tick();
      checks++;
      if (dut_vec() !== 7'b0) begin
         fails++; $display("FAIL no_clean_after_reset got=%b required=%b", dut_vec(), 7'b0);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         umidade_baixa = ($urandom_range(1, 0) == 1);
         modo          = ($urandom_range(1, 0) == 1);
         nivel_baixo   = ($urandom_range(5, 0) == 0);
         nivel_alto    = ($urandom_range(4, 0) == 0);
         erro_in       = ($urandom_range(29, 0) == 0);
         reconhece     = ($urandom_range(3, 0) == 0);
         reset         = ($urandom_range(99, 0) == 0);
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL random_vec cyc=%0d phase=%s got=%b required=%b",
                     i, m_phase, dut_vec(), exp_vec());
         end
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_asp_cycle();
      test_fill_then_drip();
      test_fill_timeout();
      test_validator_fault();
      test_early_stop_reset();
      test_random();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
